// File: rtl/q_sys_cpu_mul_sequencer_if.sv
// q_sys_cpu_mul_sequencer_if
// Bundles the execute-stage handshake and the multiplier-cell bus of the
// multiply sequencer. The slave modport is the sequencer's view, and the
// master modport is the execute stage / cell side.
// out_ovf exists only when Q_SYS_CPU_MUL_OVF_EN is defined.
interface q_sys_cpu_mul_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef Q_SYS_CPU_MUL_OVF_EN
  logic        out_ovf;
`endif
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_src1,
    input  in_src2,
    input  in_mode,
    input  flush,
    output out_valid,
    input  out_ready,
    output out_result,
`ifdef Q_SYS_CPU_MUL_OVF_EN
    output out_ovf,
`endif
    output cell_src1,
    output cell_src2,
    output cell_en,
    input  cell_p1,
    input  cell_p2,
    input  cell_p3
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_src1,
    output in_src2,
    output in_mode,
    output flush,
    input  out_valid,
    output out_ready,
    input  out_result,
`ifdef Q_SYS_CPU_MUL_OVF_EN
    input  out_ovf,
`endif
    input  cell_src1,
    input  cell_src2,
    input  cell_en,
    output cell_p1,
    output cell_p2,
    output cell_p3
  );
endinterface

// File: rtl/q_sys_cpu_mul_sequencer.sv
// q_sys_cpu_mul_sequencer
// Sequences the 16x16 three-product multiplier cell to build the low word
// (MUL) or one of the signed/unsigned high words (MULXSS/MULXSU/MULXUU)
// of a 32x32 product.
// Pass 1 sends {a,b}, and the cell returns al*bl, al*bh and ah*bl.
// Pass 2 sends {ah,bh}, and product p1 supplies ah*bh.
// Optional feature: define Q_SYS_CPU_MUL_OVF_EN to add out_ovf. In that
// build MUL also runs pass 2 so that it can judge signed 32-bit overflow.
module q_sys_cpu_mul_sequencer #(
  parameter int CELL_LAT    = 1,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  q_sys_cpu_mul_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    W1   = 3'd2,
    P2   = 3'd3,
    W2   = 3'd4,
    SUM  = 3'd5,
    DONE = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULXSS = 2'b01,
    MODE_MULXSU = 2'b10,
    MODE_MULXUU = 2'b11
  } mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] lo_hi_q, lo_hi_d;
`ifdef Q_SYS_CPU_MUL_OVF_EN
  logic [31:0] lo_lo_q, lo_lo_d;
  logic        ovf_q, ovf_d;
`endif
  logic [31:0] result_q, result_d;
  logic [31:0] cell_src1_q, cell_src1_d;
  logic [31:0] cell_src2_q, cell_src2_d;
  logic        cell_en_q, cell_en_d;

  logic [63:0] lo64_now;
  logic [31:0] hi_u;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] hi_ss;
  logic [31:0] hi_su;
  logic        needs_p2;
  logic        zero_op;

  // Combines the pass-1 partial products and applies the signed high-word corrections
  always_comb begin
    lo64_now = '0;
    hi_u     = '0;
    corr_a   = '0;
    corr_b   = '0;
    hi_ss    = '0;
    hi_su    = '0;
    lo64_now = {32'd0, bus.cell_p1}
             + ({31'd0, ({1'b0, bus.cell_p2} + {1'b0, bus.cell_p3})} << 16);
    hi_u     = lo_hi_q + bus.cell_p1;
    corr_a   = a_q[31] ? b_q : 32'd0;
    corr_b   = b_q[31] ? a_q : 32'd0;
    hi_ss    = hi_u - corr_a - corr_b;
    hi_su    = hi_u - corr_a;
  end

  // Decides whether the current operation needs the second cell pass, and detects a zero operand
  always_comb begin
    needs_p2 = 1'b0;
    zero_op  = 1'b0;
`ifdef Q_SYS_CPU_MUL_OVF_EN
    needs_p2 = 1'b1;
`else
    needs_p2 = (mode_q != MODE_MUL);
`endif
    zero_op  = ZERO_BYPASS && ((bus.in_src1 == 32'd0) || (bus.in_src2 == 32'd0));
  end

  // Computes the next-state logic, the cell operand sequencing and the result assembly
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    lo_hi_d     = lo_hi_q;
`ifdef Q_SYS_CPU_MUL_OVF_EN
    lo_lo_d     = lo_lo_q;
    ovf_d       = ovf_q;
`endif
    result_d    = result_q;
    cell_src1_d = cell_src1_q;
    cell_src2_d = cell_src2_q;
    cell_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.in_src1;
          b_d    = bus.in_src2;
          mode_d = mode_e'(bus.in_mode);
          if (zero_op) begin
            state_d  = DONE;
            result_d = 32'd0;
`ifdef Q_SYS_CPU_MUL_OVF_EN
            ovf_d    = 1'b0;
`endif
          end else begin
            state_d     = P1;
            cell_src1_d = bus.in_src1;
            cell_src2_d = bus.in_src2;
            cell_en_d   = 1'b1;
          end
        end
      end

      P1, W1: begin
        if ((state_q == P1) && (CELL_LAT > 1)) begin
          state_d = W1;
        end else if (needs_p2) begin
          state_d     = P2;
          cell_src1_d = {16'd0, a_q[31:16]};
          cell_src2_d = {16'd0, b_q[31:16]};
          cell_en_d   = 1'b1;
        end else begin
          state_d = SUM;
        end
      end

      P2: begin
        lo_hi_d = lo64_now[63:32];
`ifdef Q_SYS_CPU_MUL_OVF_EN
        lo_lo_d = lo64_now[31:0];
`endif
        state_d = (CELL_LAT > 1) ? W2 : SUM;
      end

      W2: begin
        state_d = SUM;
      end

      SUM: begin
        state_d = DONE;
        case (mode_q)
          MODE_MUL: begin
`ifdef Q_SYS_CPU_MUL_OVF_EN
            result_d = lo_lo_q;
            ovf_d    = (hi_ss != {32{lo_lo_q[31]}});
`else
            result_d = lo64_now[31:0];
`endif
          end
          MODE_MULXSS: result_d = hi_ss;
          MODE_MULXSU: result_d = hi_su;
          default:     result_d = hi_u;
        endcase
`ifdef Q_SYS_CPU_MUL_OVF_EN
        if (mode_q != MODE_MUL) begin
          ovf_d = 1'b0;
        end
`endif
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush kills any in-flight operation. It outranks out_ready and keeps the cell quiet.
    if (bus.flush && (state_q != IDLE)) begin
      state_d     = IDLE;
      cell_en_d   = 1'b0;
      cell_src1_d = cell_src1_q;
      cell_src2_d = cell_src2_q;
    end
  end

  // Registers the sequencer state, the operands, the partial sums and the cell drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_MUL;
      a_q         <= '0;
      b_q         <= '0;
      lo_hi_q     <= '0;
`ifdef Q_SYS_CPU_MUL_OVF_EN
      lo_lo_q     <= '0;
      ovf_q       <= 1'b0;
`endif
      result_q    <= '0;
      cell_src1_q <= '0;
      cell_src2_q <= '0;
      cell_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lo_hi_q     <= lo_hi_d;
`ifdef Q_SYS_CPU_MUL_OVF_EN
      lo_lo_q     <= lo_lo_d;
      ovf_q       <= ovf_d;
`endif
      result_q    <= result_d;
      cell_src1_q <= cell_src1_d;
      cell_src2_q <= cell_src2_d;
      cell_en_q   <= cell_en_d;
    end
  end

  // Drives the handshake and cell outputs straight from the registered state
  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == DONE);
    bus.out_result = result_q;
`ifdef Q_SYS_CPU_MUL_OVF_EN
    bus.out_ovf    = ovf_q;
`endif
    bus.cell_src1  = cell_src1_q;
    bus.cell_src2  = cell_src2_q;
    bus.cell_en    = cell_en_q;
  end

endmodule

// File: tb/tb_q_sys_cpu_mul_sequencer.sv
// tb_q_sys_cpu_mul_sequencer
// Directed vectors with hand-computed results for the multiply sequencer.
// It includes a one-clock-latency model of the 16x16 multiplier cell.
module tb_q_sys_cpu_mul_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   en_count = 0;
`ifdef Q_SYS_CPU_MUL_OVF_EN
  localparam int MulLat = 4;
  logic last_ovf;
`else
  localparam int MulLat = 3;
`endif

  always #5 clk = ~clk;

  q_sys_cpu_mul_sequencer_if bus ();

  q_sys_cpu_mul_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier cell: captures the three unsigned 16x16 products one clock after enable
  always @(posedge clk) begin
    if (reset) begin
      bus.cell_p1 <= 32'd0;
      bus.cell_p2 <= 32'd0;
      bus.cell_p3 <= 32'd0;
    end else if (bus.cell_en) begin
      bus.cell_p1 <= {16'd0, bus.cell_src1[15:0]} * {16'd0, bus.cell_src2[15:0]};
      bus.cell_p2 <= {16'd0, bus.cell_src1[15:0]} * {16'd0, bus.cell_src2[31:16]};
      bus.cell_p3 <= {16'd0, bus.cell_src1[31:16]} * {16'd0, bus.cell_src2[15:0]};
    end
  end

  // Counts the clocks in which the cell is enabled
  always @(posedge clk) begin
    if (bus.cell_en) en_count <= en_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one operation at a negedge, waits (bounded) for out_valid and checks latency and result
  task automatic applyStimulus(input string tag, input logic [1:0] mode,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int exp_lat);
    int k;
    checkOutput({tag, " ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_src1   = a;
    bus.in_src2   = b;
    bus.in_mode   = mode;
    bus.out_ready = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && k < 20);
    checkOutput({tag, " lat"}, 32'(k), 32'(exp_lat));
    checkOutput({tag, " res"}, bus.out_result, exp_res);
`ifdef Q_SYS_CPU_MUL_OVF_EN
    last_ovf = bus.out_ovf;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    int en0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_mode   = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    checkOutput("rst in_ready",  {31'd0, bus.in_ready},  32'd1);
    checkOutput("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst out_result", bus.out_result,        32'd0);
    checkOutput("rst cell_en",   {31'd0, bus.cell_en},   32'd0);
    checkOutput("rst cell_src1", bus.cell_src1,          32'd0);
    checkOutput("rst cell_src2", bus.cell_src2,          32'd0);

    applyStimulus("mul basic", 2'b00, 32'h12345678, 32'h00000009, 32'hA3D70A38, MulLat);
    applyStimulus("mul align", 2'b00, 32'hDEADBEEF, 32'h00000010, 32'hEADBEEF0, MulLat);
    applyStimulus("xuu align", 2'b11, 32'hDEADBEEF, 32'h00000010, 32'h0000000D, 4);
    applyStimulus("xuu ones",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4);
    applyStimulus("xsu ones",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);
    applyStimulus("xss ones",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4);
    applyStimulus("xuu 2^32",  2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 4);
`ifdef Q_SYS_CPU_MUL_OVF_EN
    checkOutput("xuu ovf", {31'd0, last_ovf}, 32'd0);
    applyStimulus("mul ovf", 2'b00, 32'h00010000, 32'h00010000, 32'h00000000, MulLat);
    checkOutput("mul ovf flag", {31'd0, last_ovf}, 32'd1);
    applyStimulus("mul neg", 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MulLat);
    checkOutput("mul neg flag", {31'd0, last_ovf}, 32'd0);
`endif
    applyStimulus("xss neg",   2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 4);
    applyStimulus("xsu min",   2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 4);
    applyStimulus("xss min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 4);

    en0 = en_count;
    applyStimulus("zero xss", 2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 1);
    applyStimulus("zero mul", 2'b00, 32'h00000005, 32'h00000000, 32'h00000000, 1);
    checkOutput("zero cell_en", 32'(en_count - en0), 32'd0);

    // Flush in the second cell pass
    bus.in_valid = 1'b1;
    bus.in_src1  = 32'hFFFFFFFF;
    bus.in_src2  = 32'hFFFFFFFF;
    bus.in_mode  = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush in_ready",  {31'd0, bus.in_ready},  32'd1);
    checkOutput("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("flush cell_en",   {31'd0, bus.cell_en},   32'd0);
    k = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) k++;
    end
    checkOutput("flush no valid", 32'(k), 32'd0);
    applyStimulus("post flush", 2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, MulLat);

    // Flush in IDLE does not block the same-clock accept
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_src1  = 32'd6;
    bus.in_src2  = 32'd7;
    bus.in_mode  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("idle flush acc", {31'd0, bus.in_ready}, 32'd0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    checkOutput("idle flush res", bus.out_result, 32'd42);
    @(posedge clk);
    @(negedge clk);

    // Consumer stall in DONE
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_src1   = 32'd7;
    bus.in_src2   = 32'd6;
    bus.in_mode   = 2'b00;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && k < 20);
    checkOutput("stall lat", 32'(k), 32'(MulLat));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stall result", bus.out_result, 32'd42);
      checkOutput("stall ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("release ready", {31'd0, bus.in_ready},  32'd1);
    checkOutput("release valid", {31'd0, bus.out_valid}, 32'd0);
    applyStimulus("after stall", 2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, MulLat);

    // Reset in the middle of an operation
    bus.in_valid = 1'b1;
    bus.in_src1  = 32'h12345678;
    bus.in_src2  = 32'h9ABCDEF0;
    bus.in_mode  = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst ready",  {31'd0, bus.in_ready}, 32'd1);
    checkOutput("midrst cell_en", {31'd0, bus.cell_en}, 32'd0);
    checkOutput("midrst src1",   bus.cell_src1,         32'd0);
    checkOutput("midrst result", bus.out_result,        32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
